// File: rtl/avalon_shell_width_adapter.sv
// Purpose: serialise wide Avalon-MM slave accesses into LSB-first narrow design-side beats, and gather narrow read beats back into one wide word.
// Latency: write with k enabled beats k+2 cycles, write with no enabled beats 2 cycles, read RATIO+2 cycles (all minimums).
// Backpressure: avs_s0_waitrequest is high except for the single completion cycle; design waitrequest freezes the current beat.
// Ports: clk/reset (async, active-high); avs_s0_* wide Qsys slave (address, read, write, writedata, byteenable, readdata, waitrequest);
//        avm_design_s0_* narrow master toward the design (address = {word address, beat}, read, write, writedata, readdata, waitrequest).
module avalon_shell_width_adapter #(
    parameter int WIDE_W   = 128,
    parameter int NARROW_W = 8,
    parameter int ADDR_W   = 1
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [ADDR_W-1:0]                           avs_s0_address,
    input  logic                                        avs_s0_read,
    input  logic                                        avs_s0_write,
    input  logic [WIDE_W-1:0]                           avs_s0_writedata,
    input  logic [WIDE_W/8-1:0]                         avs_s0_byteenable,
    output logic [WIDE_W-1:0]                           avs_s0_readdata,
    output logic                                        avs_s0_waitrequest,
    output logic [ADDR_W+$clog2(WIDE_W/NARROW_W)-1:0]   avm_design_s0_address,
    output logic                                        avm_design_s0_read,
    output logic                                        avm_design_s0_write,
    output logic [NARROW_W-1:0]                         avm_design_s0_writedata,
    input  logic [NARROW_W-1:0]                         avm_design_s0_readdata,
    input  logic                                        avm_design_s0_waitrequest
);

    localparam int RATIO  = WIDE_W / NARROW_W;
    localparam int BEAT_W = $clog2(RATIO);
    localparam int LANES  = NARROW_W / 8;
    localparam int BE_W   = WIDE_W / 8;

    typedef enum logic [1:0] {IDLE, WR_BEAT, RD_BEAT, DONE} state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [ADDR_W-1:0]   addr_q;
    logic [WIDE_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [WIDE_W-1:0]   rbuf;

    // A beat is enabled when any of its byte lanes is enabled.
    function automatic logic [RATIO-1:0] beat_enables(input logic [BE_W-1:0] b);
        logic [RATIO-1:0] en;
        for (int i = 0; i < RATIO; i++) begin
            en[i] = |b[i*LANES +: LANES];
        end
        return en;
    endfunction

    // Returns {found, index} of the lowest enabled beat at or above start.
    // Scanning downwards lets the last hit be the lowest one.
    function automatic logic [BEAT_W:0] first_from(input logic [RATIO-1:0] en, input int start);
        logic              found;
        logic [BEAT_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (i >= start && en[i]) begin
                found = 1'b1;
                idx   = BEAT_W'(i);
            end
        end
        return {found, idx};
    endfunction

    logic [BEAT_W:0]     first_hit;
    logic [BEAT_W:0]     next_hit;
    logic [BEAT_W-1:0]   beat_inc;
    logic [WIDE_W-1:0]   rbuf_next;

    always_comb begin
        first_hit = first_from(beat_enables(avs_s0_byteenable), 0);
        next_hit  = first_from(beat_enables(be_q), int'(beat) + 1);
        beat_inc  = beat + 1'b1;
        // The final slice is merged here so the wide word can be loaded
        // on the same edge that accepts the last narrow beat.
        rbuf_next = rbuf;
        rbuf_next[beat*NARROW_W +: NARROW_W] = avm_design_s0_readdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            beat                    <= '0;
            addr_q                  <= '0;
            wdata_q                 <= '0;
            be_q                    <= '0;
            rbuf                    <= '0;
            avs_s0_readdata         <= '0;
            avs_s0_waitrequest      <= 1'b1;
            avm_design_s0_address   <= '0;
            avm_design_s0_read      <= 1'b0;
            avm_design_s0_write     <= 1'b0;
            avm_design_s0_writedata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Write wins over a simultaneous (illegal) read.
                    if (avs_s0_write) begin
                        addr_q  <= avs_s0_address;
                        wdata_q <= avs_s0_writedata;
                        be_q    <= avs_s0_byteenable;
                        if (first_hit[BEAT_W]) begin
                            beat                    <= first_hit[BEAT_W-1:0];
                            avm_design_s0_write     <= 1'b1;
                            avm_design_s0_address   <= {avs_s0_address, first_hit[BEAT_W-1:0]};
                            avm_design_s0_writedata <= avs_s0_writedata[first_hit[BEAT_W-1:0]*NARROW_W +: NARROW_W];
                            state                   <= WR_BEAT;
                        end else begin
                            // Nothing to write: complete without touching the design.
                            avs_s0_waitrequest <= 1'b0;
                            state              <= DONE;
                        end
                    end else if (avs_s0_read) begin
                        addr_q                <= avs_s0_address;
                        beat                  <= '0;
                        avm_design_s0_read    <= 1'b1;
                        avm_design_s0_address <= {avs_s0_address, {BEAT_W{1'b0}}};
                        state                 <= RD_BEAT;
                    end
                end

                WR_BEAT: begin
                    if (!avm_design_s0_waitrequest) begin
                        if (next_hit[BEAT_W]) begin
                            beat                    <= next_hit[BEAT_W-1:0];
                            avm_design_s0_address   <= {addr_q, next_hit[BEAT_W-1:0]};
                            avm_design_s0_writedata <= wdata_q[next_hit[BEAT_W-1:0]*NARROW_W +: NARROW_W];
                        end else begin
                            avm_design_s0_write     <= 1'b0;
                            avm_design_s0_writedata <= '0;
                            avs_s0_waitrequest      <= 1'b0;
                            state                   <= DONE;
                        end
                    end
                end

                RD_BEAT: begin
                    if (!avm_design_s0_waitrequest) begin
                        rbuf <= rbuf_next;
                        if (beat == BEAT_W'(RATIO - 1)) begin
                            avm_design_s0_read <= 1'b0;
                            avs_s0_readdata    <= rbuf_next;
                            avs_s0_waitrequest <= 1'b0;
                            beat               <= '0;
                            state              <= DONE;
                        end else begin
                            beat                  <= beat_inc;
                            avm_design_s0_address <= {addr_q, beat_inc};
                        end
                    end
                end

                DONE: begin
                    avs_s0_waitrequest <= 1'b1;
                    state              <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_shell_width_adapter.sv
// Purpose: self-checking bench for avalon_shell_width_adapter at default widths (128 -> 8).
// Latency: each command is timed from the cycle it is presented to the cycle waitrequest drops.
// Backpressure: a design-side responder can stall a chosen beat for a chosen number of cycles.
module tb_avalon_shell_width_adapter;

    localparam int WIDE_W   = 128;
    localparam int NARROW_W = 8;
    localparam int ADDR_W   = 1;
    localparam int RATIO    = 16;
    localparam int DA_W     = 5;

    logic                clk;
    logic                reset;
    logic [ADDR_W-1:0]   avs_address;
    logic                avs_read;
    logic                avs_write;
    logic [WIDE_W-1:0]   avs_writedata;
    logic [WIDE_W/8-1:0] avs_byteenable;
    logic [WIDE_W-1:0]   avs_readdata;
    logic                avs_waitrequest;
    logic [DA_W-1:0]     dsg_address;
    logic                dsg_read;
    logic                dsg_write;
    logic [NARROW_W-1:0] dsg_writedata;
    logic [NARROW_W-1:0] dsg_readdata;
    logic                dsg_waitrequest;

    avalon_shell_width_adapter #(
        .WIDE_W   (WIDE_W),
        .NARROW_W (NARROW_W),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .avs_s0_address            (avs_address),
        .avs_s0_read               (avs_read),
        .avs_s0_write              (avs_write),
        .avs_s0_writedata          (avs_writedata),
        .avs_s0_byteenable         (avs_byteenable),
        .avs_s0_readdata           (avs_readdata),
        .avs_s0_waitrequest        (avs_waitrequest),
        .avm_design_s0_address     (dsg_address),
        .avm_design_s0_read        (dsg_read),
        .avm_design_s0_write       (dsg_write),
        .avm_design_s0_writedata   (dsg_writedata),
        .avm_design_s0_readdata    (dsg_readdata),
        .avm_design_s0_waitrequest (dsg_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DA_W-1:0]     addr;
        logic [NARROW_W-1:0] dat;
    } wr_exp_t;

    typedef struct {
        logic          wr;
        logic          rd;
        logic [0:0]    addr;
        logic [127:0]  wdata;
        logic [15:0]   be;
        logic [7:0]    seed;
        int            stall_beat;
        int            stall_cnt;
        int            exp_lat;
        logic [127:0]  exp_rdata;
    } vec_t;

    wr_exp_t wq[$];
    vec_t    vecs[8];

    int          n_tests = 0;
    int          n_fail  = 0;
    int          rd_seen = 0;
    int          stall_beat = -1;
    int          stall_left = 0;
    logic [7:0]  cur_seed = 8'h00;

    logic            prev_stall = 1'b0;
    logic [DA_W-1:0] prev_addr  = '0;
    logic            prev_rd    = 1'b0;
    logic            prev_wr    = 1'b0;
    logic [7:0]      prev_wd    = '0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Design-side responder and monitor: runs on the falling edge, so it
    // sees settled registered outputs and its waitrequest/readdata hold
    // across the next rising edge.
    always @(negedge clk) begin
        if (reset) begin
            prev_stall      = 1'b0;
            dsg_waitrequest = 1'b0;
        end else begin
            if (dsg_read && dsg_write) chk("rd_wr_together", 1, 0);
            if (prev_stall) begin
                chk("hold_addr", dsg_address, prev_addr);
                chk("hold_req", {dsg_read, dsg_write}, {prev_rd, prev_wr});
                if (prev_wr) chk("hold_wdata", dsg_writedata, prev_wd);
            end
            dsg_waitrequest = 1'b0;
            if ((dsg_read || dsg_write) && int'(dsg_address[3:0]) == stall_beat && stall_left > 0) begin
                dsg_waitrequest = 1'b1;
                stall_left--;
            end
            dsg_readdata = cur_seed + {4'b0000, dsg_address[3:0]};
            if (dsg_write && !dsg_waitrequest) begin
                if (wq.size() == 0) begin
                    chk("unexpected_write", {dsg_address, dsg_writedata}, 0);
                end else begin
                    wr_exp_t e;
                    e = wq.pop_front();
                    chk("wr_addr", dsg_address, e.addr);
                    chk("wr_data", dsg_writedata, e.dat);
                end
            end
            if (dsg_read && !dsg_waitrequest) rd_seen++;
            prev_stall = (dsg_read || dsg_write) && dsg_waitrequest;
            prev_addr  = dsg_address;
            prev_rd    = dsg_read;
            prev_wr    = dsg_write;
            prev_wd    = dsg_writedata;
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int rd0;
        logic done;
        stall_beat = v.stall_beat;
        stall_left = v.stall_cnt;
        cur_seed   = v.seed;
        rd0        = rd_seen;
        if (v.wr) begin
            for (int b = 0; b < RATIO; b++) begin
                if (v.be[b]) begin
                    wr_exp_t e;
                    e.addr = {v.addr, 4'(b)};
                    e.dat  = v.wdata[b*8 +: 8];
                    wq.push_back(e);
                end
            end
        end
        @(negedge clk);
        avs_address    = v.addr;
        avs_writedata  = v.wdata;
        avs_byteenable = v.be;
        avs_write      = v.wr;
        avs_read       = v.rd;
        lat  = 1;
        done = 1'b0;
        while (!done && lat < 60) begin
            @(negedge clk);
            lat++;
            if (!avs_waitrequest) done = 1'b1;
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_readdata", idx), avs_readdata, v.exp_rdata);
        chk($sformatf("v%0d_writes_left", idx), wq.size(), 0);
        wq.delete();
        chk($sformatf("v%0d_rd_beats", idx), rd_seen - rd0, (v.rd && !v.wr) ? 16 : 0);
        @(negedge clk);
        chk($sformatf("v%0d_wait_one_cycle", idx), avs_waitrequest, 1);
    endtask

    initial begin
        logic found;
        int   low_seen;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 128'h0F0E0D0C0B0A09080706050403020100, 16'hFFFF, 8'h00, -1, 0, 18, 128'h0};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 128'h11223344556677889900AABBCCDDEEFF, 16'h8001, 8'h00, -1, 0, 4, 128'h0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF, 16'h0000, 8'h00, -1, 0, 2, 128'h0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 128'h0, 16'hFFFF, 8'h00, -1, 0, 18, 128'h0F0E0D0C0B0A09080706050403020100};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 128'h0, 16'h0000, 8'h40, 7, 3, 21, 128'h4F4E4D4C4B4A49484746454443424140};
        vecs[5] = '{1'b1, 1'b1, 1'b1, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF, 16'h00F0, 8'h00, -1, 0, 6, 128'h4F4E4D4C4B4A49484746454443424140};
        vecs[6] = '{1'b1, 1'b0, 1'b0, 128'h00112233445566778899AABBCCDDEEFF, 16'h0101, 8'h00, -1, 0, 4, 128'h4F4E4D4C4B4A49484746454443424140};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 16'h0F00, 8'h00, 9, 2, 8, 128'h4F4E4D4C4B4A49484746454443424140};

        reset           = 1'b1;
        avs_address     = '0;
        avs_read        = 1'b0;
        avs_write       = 1'b0;
        avs_writedata   = '0;
        avs_byteenable  = '0;
        dsg_readdata    = '0;
        dsg_waitrequest = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_waitrequest", avs_waitrequest, 1);
        chk("reset_readdata", avs_readdata, 0);
        chk("reset_design_req", {dsg_read, dsg_write}, 0);
        chk("reset_design_addr", dsg_address, 0);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Reset in the middle of a read at beat 5: no completion may follow.
        stall_beat = -1;
        stall_left = 0;
        cur_seed   = 8'h80;
        @(negedge clk);
        avs_address = 1'b1;
        avs_read    = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dsg_read && dsg_address[3:0] == 4'd5) found = 1'b1;
        end
        chk("mid_reach_beat5", found, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_waitrequest", avs_waitrequest, 1);
        chk("mid_reset_design_req", {dsg_read, dsg_write}, 0);
        chk("mid_reset_design_addr", dsg_address, 0);
        chk("mid_reset_readdata", avs_readdata, 0);
        avs_read = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        low_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (!avs_waitrequest || dsg_read || dsg_write) low_seen++;
        end
        chk("mid_reset_no_done", low_seen, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
